// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and its neighbours (ALUControl).
// MC_ADDI_EN adds the ADDIEX/ADDIWB states; their encodings are reserved here either way.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// State-to-control-word decoder for the multicycle control FSM (Moore, plus mem_ready gating in FETCH).
// MC_ADDI_EN enables decode of the ADDIEX/ADDIWB states; otherwise they decode as idle.
import mc_pkg::*;

module mc_output_decode (
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic       force_idle_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_BRANCH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase

        // Reset holds the FETCH selects but must never issue a memory or register strobe.
        if (force_idle_i) begin
            ctrl_o           = '0;
            ctrl_o.alu_src_b = SRCB_FOUR;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequencing, mem_ready stalls, retire counter.
// Define MC_ADDI_EN to add ADDI support (states ADDIEX/ADDIWB).
import mc_pkg::*;

module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    ctrl_t            ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`endif
            default:  state_d = S_FETCH;
        endcase
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    mc_output_decode u_decode (
        .state_i      (state_q),
        .mem_ready_i  (mem_ready),
        .force_idle_i (reset),
        .ctrl_o       (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors, expectations queued, checked on negedge.
// Build with MC_ADDI_EN defined to exercise the ADDI path; expectations follow the same macro.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  Op;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_control #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .Op          (Op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe field order: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA
    localparam logic [15:0] W_RST = {10'b0000000000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] W_F1  = {10'b1001001000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] W_F0  = {10'b0001000000, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] W_S1  = {10'b0000000000, 2'b11, 2'b00, 2'b00};
    localparam logic [15:0] W_S2  = {10'b0000000001, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] W_S3  = {10'b0011000000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] W_S4  = {10'b0000010010, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] W_S5  = {10'b0010100000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] W_S6  = {10'b0000000001, 2'b00, 2'b10, 2'b00};
    localparam logic [15:0] W_S7  = {10'b0000000110, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] W_S8  = {10'b0100000001, 2'b00, 2'b01, 2'b01};
    localparam logic [15:0] W_S9  = {10'b1000000000, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] W_S10 = {10'b0000000001, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] W_S11 = {10'b0000000010, 2'b00, 2'b00, 2'b00};

`ifdef MC_ADDI_EN
    localparam int ADDI_RET = 1;
`else
    localparam int ADDI_RET = 0;
`endif

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] w;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   row_no = 0;

    logic [15:0] obs_w;
    assign obs_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    task automatic row(input logic r, input logic [5:0] op_v, input logic mr,
                       input logic [3:0] st, input logic [15:0] w, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = r;
        Op        = op_v;
        mem_ready = mr;
        e.st  = st;
        e.w   = w;
        e.cnt = 32'(c);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks += 3;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state row %0d: got %0d want %0d", row_no, state, e.st);
            end
            if (obs_w !== e.w) begin
                errors++;
                $display("FAIL ctrl row %0d: got %b want %b", row_no, obs_w, e.w);
            end
            if (instr_count !== e.cnt) begin
                errors++;
                $display("FAIL count row %0d: got %0d want %0d", row_no, instr_count, e.cnt);
            end
            $display("row %0d: state=%0d ctrl=%b count=%0d", row_no, state, obs_w, instr_count);
            row_no++;
        end
    end

    initial begin
        int b;
        reset     = 1'b1;
        Op        = 6'h00;
        mem_ready = 1'b0;

        // Reset held, then released
        row(1, 6'h23, 1, 4'd0, W_RST, 0);
        row(1, 6'h23, 1, 4'd0, W_RST, 0);
        // LW, no stalls
        row(0, 6'h23, 1, 4'd0, W_F1, 0);
        row(0, 6'h23, 1, 4'd1, W_S1, 0);
        row(0, 6'h23, 1, 4'd2, W_S2, 0);
        row(0, 6'h23, 1, 4'd3, W_S3, 0);
        row(0, 6'h23, 1, 4'd4, W_S4, 0);
        // SW: 3 fetch stalls, 2 write stalls
        row(0, 6'h2B, 0, 4'd0, W_F0, 1);
        row(0, 6'h2B, 0, 4'd0, W_F0, 1);
        row(0, 6'h2B, 0, 4'd0, W_F0, 1);
        row(0, 6'h2B, 1, 4'd0, W_F1, 1);
        row(0, 6'h2B, 1, 4'd1, W_S1, 1);
        row(0, 6'h2B, 1, 4'd2, W_S2, 1);
        row(0, 6'h2B, 0, 4'd5, W_S5, 1);
        row(0, 6'h2B, 0, 4'd5, W_S5, 1);
        row(0, 6'h2B, 1, 4'd5, W_S5, 1);
        // R-type then BEQ
        row(0, 6'h00, 1, 4'd0, W_F1, 2);
        row(0, 6'h00, 1, 4'd1, W_S1, 2);
        row(0, 6'h00, 1, 4'd6, W_S6, 2);
        row(0, 6'h00, 1, 4'd7, W_S7, 2);
        row(0, 6'h04, 1, 4'd0, W_F1, 3);
        row(0, 6'h04, 1, 4'd1, W_S1, 3);
        row(0, 6'h04, 1, 4'd8, W_S8, 3);
        // Jump
        row(0, 6'h02, 1, 4'd0, W_F1, 4);
        row(0, 6'h02, 1, 4'd1, W_S1, 4);
        row(0, 6'h02, 1, 4'd9, W_S9, 4);
        // Illegal opcode
        row(0, 6'h3F, 1, 4'd0, W_F1, 5);
        row(0, 6'h3F, 1, 4'd1, W_S1, 5);
        // ADDI (legal only with the option)
        row(0, 6'h08, 1, 4'd0, W_F1, 5);
        row(0, 6'h08, 1, 4'd1, W_S1, 5);
`ifdef MC_ADDI_EN
        row(0, 6'h08, 1, 4'd10, W_S10, 5);
        row(0, 6'h08, 1, 4'd11, W_S11, 5);
`endif
        b = 5 + ADDI_RET;
        // LW with Op disturbed after S2, plus a read stall
        row(0, 6'h23, 1, 4'd0, W_F1, b);
        row(0, 6'h23, 1, 4'd1, W_S1, b);
        row(0, 6'h23, 1, 4'd2, W_S2, b);
        row(0, 6'h00, 0, 4'd3, W_S3, b);
        row(0, 6'h3F, 1, 4'd3, W_S3, b);
        row(0, 6'h00, 1, 4'd4, W_S4, b);
        // Reset asserted mid-stall in S3, then fetch resumes
        row(0, 6'h23, 1, 4'd0, W_F1, b + 1);
        row(0, 6'h23, 1, 4'd1, W_S1, b + 1);
        row(0, 6'h23, 1, 4'd2, W_S2, b + 1);
        row(0, 6'h23, 0, 4'd3, W_S3, b + 1);
        row(1, 6'h23, 0, 4'd0, W_RST, 0);
        row(1, 6'h23, 1, 4'd0, W_RST, 0);
        row(0, 6'h23, 1, 4'd0, W_F1, 0);
        row(0, 6'h23, 1, 4'd1, W_S1, 0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of ALUControl and drives its ALUOp input.
- Decodes the 6-bit opcode from the instruction register.
- Sequences Fetch/Decode/Execute/Memory/Writeback, generating all datapath mux selects and write strobes.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  opcode field, IR[31:26]; valid from Decode onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write if ALU Zero.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  register write data from MDR.
- IRWrite  out  1  load the instruction register.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- ALUOp  out  2  to ALUControl: 00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM with a registered state.
- Outputs are pure combinational decode of the state, except the mem_ready gating listed below.
- Unlisted strobes are 0; unlisted selects are 0.
- States and transitions:
  - S0 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite equal mem_ready. Go to S1 when mem_ready, else stay.
  - S1 DECODE: ALUSrcB=11, ALUOp=00.
    - Op 0x23 (LW) or 0x2B (SW) go to S2.
    - Op 0x00 (R-type) goes to S6.
    - Op 0x04 (BEQ) goes to S8.
    - Op 0x02 (J) goes to S9.
    - Any other opcode is illegal and goes to S0; it is not counted.
  - S2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW goes to S3; SW goes to S5.
  - S3 MEMRD: MemRead=1, IorD=1. Go to S4 when mem_ready, else stay.
  - S4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to S0.
  - S5 MEMWR: MemWrite=1, IorD=1. Go to S0 when mem_ready, else stay.
  - S6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to S7.
  - S7 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to S0.
  - S8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to S0.
  - S9 JUMP: PCWrite=1, PCSource=10. Go to S0.
  - Unused encodings go to S0 on the next edge, with all strobes 0 while in them.
- Op is sampled in S1 and S2 only; changes to Op in any other state have no effect.
- Instruction cycle counts with no stalls:
  - LW: 5 cycles.
  - SW: 4 cycles.
  - R-type: 4 cycles.
  - BEQ: 3 cycles.
  - J: 3 cycles.
  - Each stall cycle in S0, S3 or S5 adds 1 cycle.
- instr_count:
  - Increments by 1 on the edge leaving S4, S5 (with mem_ready), S7, S8 or S9.
  - Wraps modulo 2^CNT_W.
- Reset, asserted at any time, including mid-instruction or mid-stall:
  - state is immediately S0 and instr_count is 0.
  - While reset is high, all strobes are forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
  - Selects hold their S0 values: ALUSrcB=01, all others 0.
  - Normal S0 behaviour starts on the first clk edge after deassertion.

Optional Feature:
- Macro MC_ADDI_EN.
- When defined:
  - Op 0x08 (ADDI) in S1 goes to S10 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - S10 goes to S11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
  - S11 goes to S0 and counts as retired.
- When undefined, 0x08 is illegal (S1 goes to S0, not counted), and encodings 10 and 11 are unused.

Decomposition:
- Shared package (mc_pkg) holds:
  - state encodings S_FETCH through S_ADDIWB.
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - ALUOp codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, consumed by ALUControl as well.
- One sub-module, mc_output_decode: a combinational state-to-control-word decoder.
- The state register, next-state logic and counter stay in the top module.

Test Plan:
- LW flow: reset, Op=0x23, mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in S4; instr_count=1 after 5 cycles.
- Stalls: SW with mem_ready low for 3 cycles in S0 and 2 cycles in S5 → IRWrite and PCWrite stay 0 while stalled; 9 cycles total; MemWrite held high throughout S5.
- R-type then BEQ back to back → ALUOp=10 in S6, ALUOp=01 and PCWriteCond=1 in S8; instr_count=2 after 7 cycles.
- Illegal Op=0x3F → S1 goes to S0, instr_count unchanged, no strobes asserted in S1.
- Reset in S3 mid-stall → state=0 asynchronously, all strobes 0 during reset, instr_count=0; fetch resumes on the first edge after release.
- With MC_ADDI_EN, Op=0x08 → states 0,1,10,11,0 with RegWrite=1 in S11. Without it, the same stimulus gives 0,1,0 and instr_count unchanged.
